// File: rtl/r5p_htif_pkg.sv
// r5p_htif_pkg
// Shared types and constants for the HTIF mailbox peripheral.
//   htif_cmd_t   : 64-bit tohost/fromhost layout (device, cmd, payload)
//   htif_state_t : command FSM states
//   merge_bytes  : byte-enable merge of a write into an existing word
package r5p_htif_pkg;

    typedef struct packed {
        logic [7:0]  device;
        logic [7:0]  cmd;
        logic [47:0] payload;
    } htif_cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CHAR = 2'd1,
        ACK  = 2'd2,
        HALT = 2'd3
    } htif_state_t;

    localparam logic [7:0] HTIF_DEV_SYSCALL = 8'd0;
    localparam logic [7:0] HTIF_DEV_CONSOLE = 8'd1;
    localparam logic [7:0] HTIF_CMD_PUTCHAR = 8'd1;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] wdt,
        input logic [3:0]  ben
    );
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (ben[i]) res[8*i +: 8] = wdt[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/r5p_htif_if.sv
// r5p_htif_if
// TCB request/response bundle between the address decoder and the HTIF.
//   vld/wen/adr/ben/wdt : request (manager -> subordinate)
//   rdt/err             : response, valid one cycle after the transfer
//   rdy                 : subordinate ready
// Handshake: a transfer happens on a rising clk edge where vld && rdy;
// the manager holds the request stable while vld is high and rdy is low.
interface r5p_htif_if;
    logic        vld;
    logic        wen;
    logic [31:0] adr;
    logic [3:0]  ben;
    logic [31:0] wdt;
    logic [31:0] rdt;
    logic        err;
    logic        rdy;

    modport master (output vld, wen, adr, ben, wdt, input  rdt, err, rdy);
    modport slave  (input  vld, wen, adr, ben, wdt, output rdt, err, rdy);
endinterface

// File: rtl/r5p_htif_timeout.sv
// r5p_htif_timeout
// Saturating cycle counter started at reset release.
//   clk, rst : clock, asynchronous active-low reset
//   timeout  : sticky flag, set on the TIMEOUT-th cycle; never set when TIMEOUT=0
module r5p_htif_timeout #(
    parameter int unsigned TIMEOUT = 20000
) (
    input  logic clk,
    input  logic rst,
    output logic timeout
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign timeout = 1'b0;
        end else begin : g_cnt
            localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            logic [CW-1:0] r_cnt;
            logic          r_timeout;

            // Counter freezes once the flag is set, so it never wraps.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cnt     <= '0;
                    r_timeout <= 1'b0;
                end else if (!r_timeout) begin
                    if (r_cnt == CW'(TIMEOUT - 1)) r_timeout <= 1'b1;
                    else                           r_cnt     <= r_cnt + 1'b1;
                end
            end

            assign timeout = r_timeout;
        end
    endgenerate

endmodule

// File: rtl/r5p_htif.sv
// r5p_htif
// HTIF mailbox peripheral: tohost/fromhost registers, halt and console
// putchar command decode, timeout flag.
//   clk, rst   : clock, asynchronous active-low reset
//   tcb        : TCB subordinate port (read data/error one cycle after transfer)
//   con_vld/con_dat/con_rdy : console character handshake
//   halt, exit_code         : sticky halt flag and tohost[31:1] captured at halt
//   timeout                 : sticky cycle-limit flag
//   dbg_state               : current FSM state
module r5p_htif
    import r5p_htif_pkg::*;
#(
    parameter logic [31:0] TOHOST   = 32'h8000_1000,
    parameter logic [31:0] FROMHOST = 32'h8000_1040,
    parameter int unsigned TIMEOUT  = 20000
) (
    input  logic         clk,
    input  logic         rst,
    r5p_htif_if.slave    tcb,
    output logic         con_vld,
    output logic [7:0]   con_dat,
    input  logic         con_rdy,
    output logic         halt,
    output logic [30:0]  exit_code,
    output logic         timeout,
    output htif_state_t  dbg_state
);

    localparam logic [31:0] TOHOST_HI   = TOHOST + 32'd4;
    localparam logic [31:0] FROMHOST_HI = FROMHOST + 32'd4;

    htif_state_t r_state, w_state_nxt;
    logic [63:0] r_tohost, r_fromhost;
    logic [7:0]  r_con_dat;
    logic        r_halt;
    logic [30:0] r_exit_code;
    logic [31:0] r_rdt;
    logic        r_err;

    logic        w_trn, w_rdy, w_con_vld;
    logic        w_sel_tl, w_sel_th, w_sel_fl, w_sel_fh, w_mapped;
    logic [31:0] w_rd_word, w_wr_word;
    logic        w_wr_ok, w_fire;
    htif_cmd_t   w_cmd;
    logic        w_cmd_halt, w_cmd_char;

    assign w_trn = tcb.vld & w_rdy;

    // Word decode; byte offset bits are ignored.
    assign w_sel_tl = (tcb.adr[31:2] == TOHOST[31:2]);
    assign w_sel_th = (tcb.adr[31:2] == TOHOST_HI[31:2]);
    assign w_sel_fl = (tcb.adr[31:2] == FROMHOST[31:2]);
    assign w_sel_fh = (tcb.adr[31:2] == FROMHOST_HI[31:2]);
    assign w_mapped = w_sel_tl | w_sel_th | w_sel_fl | w_sel_fh;

    always_comb begin
        w_rd_word = '0;
        if      (w_sel_tl) w_rd_word = r_tohost[31:0];
        else if (w_sel_th) w_rd_word = r_tohost[63:32];
        else if (w_sel_fl) w_rd_word = r_fromhost[31:0];
        else if (w_sel_fh) w_rd_word = r_fromhost[63:32];
    end

    // The addressed word after the byte-enable merge of this write.
    assign w_wr_word = merge_bytes(w_rd_word, tcb.wdt, tcb.ben);

    // Writes only land in IDLE; in HALT they are accepted and dropped.
    assign w_wr_ok = w_trn & tcb.wen & (r_state == IDLE);
    assign w_fire  = w_wr_ok & w_sel_th;

    // Command view uses the merged high word plus the stored low word.
    assign w_cmd      = htif_cmd_t'({w_wr_word, r_tohost[31:0]});
    assign w_cmd_halt = (w_cmd.device == HTIF_DEV_SYSCALL) & w_cmd.payload[0];
    assign w_cmd_char = (w_cmd.device == HTIF_DEV_CONSOLE) & (w_cmd.cmd == HTIF_CMD_PUTCHAR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rdy       = 1'b1;
        w_con_vld   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fire) begin
                    if      (w_cmd_halt) w_state_nxt = HALT;
                    else if (w_cmd_char) w_state_nxt = CHAR;
                end
            end
            CHAR: begin
                w_rdy     = 1'b0;
                w_con_vld = 1'b1;
                if (con_rdy) w_state_nxt = ACK;
            end
            ACK: begin
                w_rdy       = 1'b0;
                w_state_nxt = IDLE;
            end
            HALT: begin
                w_state_nxt = HALT;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tohost    <= '0;
            r_fromhost  <= '0;
            r_con_dat   <= '0;
            r_halt      <= 1'b0;
            r_exit_code <= '0;
            r_rdt       <= '0;
            r_err       <= 1'b0;
        end else begin
            if (r_state == ACK) begin
                r_tohost   <= '0;
                r_fromhost <= {8'd1, 8'd1, 48'd1};
            end else if (w_wr_ok) begin
                if (w_sel_tl) r_tohost[31:0]    <= w_wr_word;
                if (w_sel_fl) r_fromhost[31:0]  <= w_wr_word;
                if (w_sel_fh) r_fromhost[63:32] <= w_wr_word;
                if (w_sel_th) begin
                    // Unknown commands are discarded rather than left pending.
                    if (w_cmd_halt || w_cmd_char) r_tohost[63:32] <= w_wr_word;
                    else                          r_tohost        <= '0;
                end
            end
            if (w_fire && w_cmd_halt) begin
                r_halt      <= 1'b1;
                r_exit_code <= w_cmd.payload[31:1];
            end
            if (w_fire && !w_cmd_halt && w_cmd_char) r_con_dat <= w_cmd.payload[7:0];
            // Error flags every transfer; read data is updated by reads only.
            if (w_trn) begin
                r_err <= ~w_mapped;
                if (!tcb.wen) r_rdt <= w_rd_word;
            end
        end
    end

    r5p_htif_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .timeout (timeout)
    );

    assign tcb.rdy   = w_rdy;
    assign tcb.rdt   = r_rdt;
    assign tcb.err   = r_err;
    assign con_vld   = w_con_vld;
    assign con_dat   = r_con_dat;
    assign halt      = r_halt;
    assign exit_code = r_exit_code;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_r5p_htif.sv
// tb_r5p_htif
// Directed bench for r5p_htif with TIMEOUT=10.
module tb_r5p_htif;
    import r5p_htif_pkg::*;

    localparam logic [31:0] TOHOST   = 32'h8000_1000;
    localparam logic [31:0] FROMHOST = 32'h8000_1040;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        con_vld;
    logic [7:0]  con_dat;
    logic        con_rdy;
    logic        halt;
    logic [30:0] exit_code;
    logic        timeout;
    htif_state_t dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    r5p_htif_if tcb_if ();

    r5p_htif #(.TOHOST(TOHOST), .FROMHOST(FROMHOST), .TIMEOUT(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .tcb       (tcb_if),
        .con_vld   (con_vld),
        .con_dat   (con_dat),
        .con_rdy   (con_rdy),
        .halt      (halt),
        .exit_code (exit_code),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic do_reset();
        rst         = 1'b0;
        tcb_if.vld  = 1'b0;
        tcb_if.wen  = 1'b0;
        tcb_if.adr  = '0;
        tcb_if.ben  = '0;
        tcb_if.wdt  = '0;
        con_rdy     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // drivers: return #1 after the transfer edge
    task automatic bus_write(input logic [31:0] adr, input logic [31:0] wdt, input logic [3:0] ben);
        int guard;
        @(negedge clk);
        tcb_if.vld = 1'b1;
        tcb_if.wen = 1'b1;
        tcb_if.adr = adr;
        tcb_if.wdt = wdt;
        tcb_if.ben = ben;
        guard = 0;
        while (!tcb_if.rdy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!tcb_if.rdy) begin
            n_total++;
            $display("FAIL bus_write_rdy: rdy=%0b want 1 within 50 cycles", tcb_if.rdy);
        end
        @(posedge clk);
        #1;
        tcb_if.vld = 1'b0;
        tcb_if.wen = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] adr, output logic [31:0] rdt, output logic err);
        int guard;
        @(negedge clk);
        tcb_if.vld = 1'b1;
        tcb_if.wen = 1'b0;
        tcb_if.adr = adr;
        tcb_if.ben = 4'hF;
        guard = 0;
        while (!tcb_if.rdy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!tcb_if.rdy) begin
            n_total++;
            $display("FAIL bus_read_rdy: rdy=%0b want 1 within 50 cycles", tcb_if.rdy);
        end
        @(posedge clk);
        #1;
        tcb_if.vld = 1'b0;
        rdt = tcb_if.rdt;
        err = tcb_if.err;
    endtask

    task automatic test_reset();
        logic [31:0] rdt;
        logic        err;
        do_reset();
        #1;
        n_total++; if (tcb_if.rdy !== 1'b1) $display("FAIL reset_rdy: got %0b want 1", tcb_if.rdy); else n_pass++;
        n_total++; if (con_vld !== 1'b0) $display("FAIL reset_con_vld: got %0b want 0", con_vld); else n_pass++;
        n_total++; if (con_dat !== 8'h00) $display("FAIL reset_con_dat: got %h want 00", con_dat); else n_pass++;
        n_total++; if (halt !== 1'b0) $display("FAIL reset_halt: got %0b want 0", halt); else n_pass++;
        n_total++; if (exit_code !== 31'd0) $display("FAIL reset_exit_code: got %0d want 0", exit_code); else n_pass++;
        n_total++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %0b want 0", timeout); else n_pass++;
        n_total++; if (tcb_if.rdt !== 32'h0) $display("FAIL reset_rdt: got %h want 0", tcb_if.rdt); else n_pass++;
        n_total++; if (tcb_if.err !== 1'b0) $display("FAIL reset_err: got %0b want 0", tcb_if.err); else n_pass++;
        n_total++; if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); else n_pass++;
        bus_read(FROMHOST + 32'd4, rdt, err);
        n_total++; if (rdt !== 32'h0) $display("FAIL reset_fromhost_hi: got %h want 0", rdt); else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (9) @(posedge clk);
        #1;
        n_total++; if (timeout !== 1'b0) $display("FAIL timeout_cycle9: got %0b want 0", timeout); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (timeout !== 1'b1) $display("FAIL timeout_cycle10: got %0b want 1", timeout); else n_pass++;
        repeat (5) @(posedge clk);
        #1;
        n_total++; if (timeout !== 1'b1) $display("FAIL timeout_held: got %0b want 1", timeout); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (timeout !== 1'b0) $display("FAIL timeout_reset: got %0b want 0", timeout); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_halt_pass();
        logic [31:0] rdt;
        logic        err;
        do_reset();
        bus_write(TOHOST, 32'h1, 4'hF);
        n_total++; if (halt !== 1'b0) $display("FAIL halt_lo_only: got %0b want 0", halt); else n_pass++;
        bus_write(TOHOST + 32'd4, 32'h0, 4'hF);
        n_total++; if (halt !== 1'b1) $display("FAIL halt_pass_flag: got %0b want 1", halt); else n_pass++;
        n_total++; if (exit_code !== 31'd0) $display("FAIL halt_pass_code: got %0d want 0", exit_code); else n_pass++;
        n_total++; if (dbg_state !== HALT) $display("FAIL halt_pass_state: got %0d want %0d", dbg_state, HALT); else n_pass++;
        bus_read(TOHOST, rdt, err);
        n_total++; if (rdt !== 32'h1) $display("FAIL halt_read_tohost: got %h want 00000001", rdt); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL halt_read_err: got %0b want 0", err); else n_pass++;
        // writes in HALT are dropped
        bus_write(FROMHOST, 32'hFFFF_FFFF, 4'hF);
        bus_read(FROMHOST, rdt, err);
        n_total++; if (rdt !== 32'h0) $display("FAIL halt_write_ignored: got %h want 0", rdt); else n_pass++;
        n_total++; if (tcb_if.rdy !== 1'b1) $display("FAIL halt_rdy: got %0b want 1", tcb_if.rdy); else n_pass++;
    endtask

    task automatic test_halt_code();
        do_reset();
        bus_write(TOHOST, 32'h0000_0007, 4'hF);
        repeat (12) @(posedge clk);
        #1;
        n_total++; if (timeout !== 1'b1) $display("FAIL halt_code_pre_timeout: got %0b want 1", timeout); else n_pass++;
        bus_write(TOHOST + 32'd4, 32'h0, 4'hF);
        n_total++; if (halt !== 1'b1) $display("FAIL halt_code_flag: got %0b want 1", halt); else n_pass++;
        n_total++; if (exit_code !== 31'd3) $display("FAIL halt_code_value: got %0d want 3", exit_code); else n_pass++;
        n_total++; if (timeout !== 1'b1) $display("FAIL halt_code_timeout: got %0b want 1", timeout); else n_pass++;
    endtask

    task automatic test_putchar();
        logic [31:0] rdt;
        logic        err;
        do_reset();
        con_rdy = 1'b0;
        bus_write(TOHOST, 32'h41, 4'hF);
        bus_write(TOHOST + 32'd4, 32'h0101_0000, 4'hF);
        for (int i = 0; i < 4; i++) begin
            n_total++; if (con_vld !== 1'b1) $display("FAIL putchar_con_vld[%0d]: got %0b want 1", i, con_vld); else n_pass++;
            n_total++; if (con_dat !== 8'h41) $display("FAIL putchar_con_dat[%0d]: got %h want 41", i, con_dat); else n_pass++;
            n_total++; if (tcb_if.rdy !== 1'b0) $display("FAIL putchar_rdy[%0d]: got %0b want 0", i, tcb_if.rdy); else n_pass++;
            if (i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        con_rdy = 1'b1;
        @(posedge clk);
        #1;
        con_rdy = 1'b0;
        n_total++; if (dbg_state !== ACK) $display("FAIL putchar_ack_state: got %0d want %0d", dbg_state, ACK); else n_pass++;
        n_total++; if (con_vld !== 1'b0) $display("FAIL putchar_ack_con_vld: got %0b want 0", con_vld); else n_pass++;
        n_total++; if (tcb_if.rdy !== 1'b0) $display("FAIL putchar_ack_rdy: got %0b want 0", tcb_if.rdy); else n_pass++;
        bus_read(TOHOST, rdt, err);
        n_total++; if (rdt !== 32'h0) $display("FAIL putchar_tohost_lo: got %h want 0", rdt); else n_pass++;
        bus_read(TOHOST + 32'd4, rdt, err);
        n_total++; if (rdt !== 32'h0) $display("FAIL putchar_tohost_hi: got %h want 0", rdt); else n_pass++;
        bus_read(FROMHOST, rdt, err);
        n_total++; if (rdt !== 32'h1) $display("FAIL putchar_fromhost_lo: got %h want 00000001", rdt); else n_pass++;
        bus_read(FROMHOST + 32'd4, rdt, err);
        n_total++; if (rdt !== 32'h0101_0000) $display("FAIL putchar_fromhost_hi: got %h want 01010000", rdt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        con_rdy = 1'b1;
        bus_write(TOHOST, 32'h5A, 4'hF);
        bus_write(TOHOST + 32'd4, 32'h0101_0000, 4'hF);
        n_total++; if (tcb_if.rdy !== 1'b0) $display("FAIL b2b_rdy_c1: got %0b want 0", tcb_if.rdy); else n_pass++;
        n_total++; if (con_dat !== 8'h5A) $display("FAIL b2b_con_dat: got %h want 5a", con_dat); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (tcb_if.rdy !== 1'b0) $display("FAIL b2b_rdy_c2: got %0b want 0", tcb_if.rdy); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (tcb_if.rdy !== 1'b1) $display("FAIL b2b_rdy_c3: got %0b want 1", tcb_if.rdy); else n_pass++;
        con_rdy = 1'b0;
    endtask

    task automatic test_byte_enable();
        logic [31:0] rdt;
        logic        err;
        do_reset();
        bus_write(FROMHOST, 32'hAABB_CCDD, 4'b0010);
        bus_read(FROMHOST, rdt, err);
        n_total++; if (rdt !== 32'h0000_CC00) $display("FAIL ben_0010: got %h want 0000cc00", rdt); else n_pass++;
        bus_write(FROMHOST, 32'h1122_3344, 4'b0001);
        bus_read(FROMHOST, rdt, err);
        n_total++; if (rdt !== 32'h0000_CC44) $display("FAIL ben_merge: got %h want 0000cc44", rdt); else n_pass++;
    endtask

    task automatic test_unmapped();
        logic [31:0] rdt;
        logic        err;
        do_reset();
        bus_write(TOHOST, 32'h1234_5678, 4'hF);
        bus_read(32'h8000_1008, rdt, err);
        n_total++; if (err !== 1'b1) $display("FAIL unmapped_err: got %0b want 1", err); else n_pass++;
        n_total++; if (rdt !== 32'h0) $display("FAIL unmapped_rdt: got %h want 0", rdt); else n_pass++;
        bus_write(32'h8000_1008, 32'hFFFF_FFFF, 4'hF);
        n_total++; if (tcb_if.err !== 1'b1) $display("FAIL unmapped_wr_err: got %0b want 1", tcb_if.err); else n_pass++;
        bus_read(TOHOST, rdt, err);
        n_total++; if (rdt !== 32'h1234_5678) $display("FAIL unmapped_no_change: got %h want 12345678", rdt); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL unmapped_err_clear: got %0b want 0", err); else n_pass++;
        n_total++; if (dbg_state !== IDLE) $display("FAIL unmapped_state: got %0d want %0d", dbg_state, IDLE); else n_pass++;
    endtask

    task automatic test_other_cmd();
        logic [31:0] rdt;
        logic        err;
        do_reset();
        bus_write(TOHOST, 32'h5, 4'hF);
        bus_write(TOHOST + 32'd4, 32'h0200_0000, 4'hF);
        n_total++; if (dbg_state !== IDLE) $display("FAIL other_state: got %0d want %0d", dbg_state, IDLE); else n_pass++;
        n_total++; if (halt !== 1'b0) $display("FAIL other_halt: got %0b want 0", halt); else n_pass++;
        bus_read(TOHOST, rdt, err);
        n_total++; if (rdt !== 32'h0) $display("FAIL other_tohost_lo: got %h want 0", rdt); else n_pass++;
        bus_read(TOHOST + 32'd4, rdt, err);
        n_total++; if (rdt !== 32'h0) $display("FAIL other_tohost_hi: got %h want 0", rdt); else n_pass++;
    endtask

    task automatic test_reset_mid_char();
        do_reset();
        con_rdy = 1'b0;
        bus_write(TOHOST, 32'h42, 4'hF);
        bus_write(TOHOST + 32'd4, 32'h0101_0000, 4'hF);
        n_total++; if (con_vld !== 1'b1) $display("FAIL midchar_pre_vld: got %0b want 1", con_vld); else n_pass++;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_total++; if (con_vld !== 1'b0) $display("FAIL midchar_con_vld: got %0b want 0", con_vld); else n_pass++;
        n_total++; if (con_dat !== 8'h00) $display("FAIL midchar_con_dat: got %h want 00", con_dat); else n_pass++;
        n_total++; if (tcb_if.rdy !== 1'b1) $display("FAIL midchar_rdy: got %0b want 1", tcb_if.rdy); else n_pass++;
        n_total++; if (dbg_state !== IDLE) $display("FAIL midchar_state: got %0d want %0d", dbg_state, IDLE); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_halt_pass();
        test_halt_code();
        test_putchar();
        test_back_to_back();
        test_byte_enable();
        test_unmapped();
        test_other_cmd();
        test_reset_mid_char();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/r5p_htif.md
# r5p_htif

Synthesizable HTIF (host-target interface) peripheral for the R5P Mouse system. It is a TCB subordinate that sits downstream of the CPU, in parallel with system memory behind the address decoder, on the byte-enable side of the log-size to byte-enable converter. It holds the 64-bit `tohost`/`fromhost` mailboxes, decodes halt and console-putchar commands, and raises halt/exit-code/timeout flags so conformance runs end without testbench address snooping.

## Interface
- `TOHOST`, `32'h8000_1000`: byte address of `tohost` low word; high word at `TOHOST+4`.
- `FROMHOST`, `32'h8000_1040`: byte address of `fromhost` low word; high word at `FROMHOST+4`.
- `TIMEOUT`, `20000`: cycle limit after reset release; 0 disables the counter.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous assert, active-low.
- `tcb_vld` in 1: request valid.
- `tcb_wen` in 1: write enable.
- `tcb_adr` in 32: byte address; word-aligned, bits [1:0] ignored.
- `tcb_ben` in 4: byte enables, bit i selects `wdt[8i+7:8i]`.
- `tcb_wdt` in 32: write data.
- `tcb_rdt` out 32: read data.
- `tcb_err` out 1: error response.
- `tcb_rdy` out 1: ready; transfer `trn = tcb_vld & tcb_rdy`.
- `con_vld` out 1: console character valid.
- `con_dat` out 8: console character.
- `con_rdy` in 1: console accepts character.
- `halt` out 1: sticky, program requested halt.
- `exit_code` out 31: `tohost[31:1]` captured at halt; 0 means pass.
- `timeout` out 1: sticky, cycle limit reached.

## Operation
- Registers: `tohost[63:0]`, `fromhost[63:0]`. Field layout: `[63:56]` device, `[55:48]` cmd, `[47:0]` payload.
- Writes merge per byte under `tcb_ben` into the addressed word.
- A command fires on a write transfer to `TOHOST+4`, using the merged 64-bit value. A write to the low word alone only stores.
- FSM states:
  - IDLE: `tcb_rdy=1`.
  - Command with device 0 and `payload[0]=1` → HALT. Capture `exit_code`, set `halt`.
  - Command with device 1 and cmd 1 → CHAR. Load `con_dat=payload[7:0]`.
  - Any other command clears `tohost` next cycle and stays in IDLE.
  - CHAR: `tcb_rdy=0`, `con_vld=1`. On `con_rdy` → ACK.
  - ACK, one cycle: `tcb_rdy=0`, `tohost←0`, `fromhost←{8'd1,8'd1,48'd1}` → IDLE.
  - HALT: terminal until reset. `tcb_rdy=1`; reads still serviced; writes are accepted and ignored.
- Reads return the addressed word. Any access to an address other than the four mapped words returns `tcb_err=1` and `rdt=0`; writes to unmapped addresses have no effect.
- Timeout counter: counts `clk` cycles from reset release. At count `TIMEOUT-1` set `timeout` and stop counting; `TIMEOUT=0` never sets it.
- Reset values: `tohost=0`, `fromhost=0`, FSM=IDLE, counter=0, `tcb_rdt=0`, `tcb_err=0`, `tcb_rdy=1`, `con_vld=0`, `con_dat=0`, `halt=0`, `exit_code=0`, `timeout=0`.

## Timing
- Protocol delay DLY=1: `tcb_rdt`/`tcb_err` are valid the cycle after `trn` and held until the next read response.
- Register writes take effect at the `trn` edge. A read in the following cycle returns the new value.
- `halt` rises one cycle after the halt-command transfer.
- `con_vld` rises one cycle after the putchar-command transfer. It stays high with `con_dat` stable until the `con_rdy` cycle.
- `con_rdy` held high: CHAR lasts 1 cycle, then ACK 1 cycle. `tcb_rdy` is low for exactly 2 cycles.
- Halt and timeout in the same cycle: both flags set.
- A halt command while `timeout` is already set is still accepted.
- `rst` asserted mid-CHAR drops `con_vld` immediately (asynchronous) and restores all reset values.
- Counter saturates. No wrap-around.

## Structure
- Package `r5p_htif_pkg`:
  - Struct `htif_cmd_t` (device, cmd, payload).
  - Enum `htif_state_t` (IDLE, CHAR, ACK, HALT).
  - Constants `HTIF_DEV_SYSCALL=0`, `HTIF_DEV_CONSOLE=1`, `HTIF_CMD_PUTCHAR=1`.
- One natural sub-module: `r5p_htif_timeout`, a saturating cycle counter with parameter `TIMEOUT` and output `timeout`.

## Test plan
- Write `32'h1` to `TOHOST`, then `32'h0` to `TOHOST+4` → `halt=1` next cycle, `exit_code=0`; a read of `TOHOST` returns `32'h1`.
- Write `32'h0000_0007` to `TOHOST`, then `0` to `TOHOST+4` → `halt=1`, `exit_code=3`.
- Write `32'h41` to `TOHOST`, then `32'h0101_0000` to `TOHOST+4`, with `con_rdy` low for 3 cycles → `con_vld=1`, `con_dat=8'h41`, `tcb_rdy=0` throughout.
  - After `con_rdy`: `tohost` reads 0, `FROMHOST` reads `1`, `FROMHOST+4` reads `32'h0101_0000`.
- Write `tcb_ben=4'b0010`, `wdt=32'hAABB_CCDD` to `FROMHOST` → reads back `32'h0000_CC00`.
- Read `32'h8000_1008` → `tcb_err=1`, `rdt=0`; no state change.
- `TIMEOUT=10`, no accesses → `timeout=1` on the 10th cycle after reset release and held; `rst` low clears it.
